// File: rtl/quad_velocity_meter.sv
// Gate-window velocity meter: signed position delta of a quadrature count over back-to-back
// windows of programmable length, published with a one-cycle valid strobe.
module quad_velocity_meter #(
    parameter int unsigned CW = 14,
    parameter int unsigned GW = 24,
    parameter int unsigned VW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [CW-1:0] count_i,
    input  logic          enable_i,
    input  logic [GW-1:0] gate_len_i,
    output logic [VW-1:0] vel_o,
    output logic          vel_valid_o,
    output logic          vel_sat_o,
    output logic [CW-1:0] pos_o,
    output logic [15:0]   win_cnt_o,
    output logic          busy_o
);

    localparam int unsigned WCW = 16;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [GW-1:0] r_timer;
    logic [CW-1:0] r_base;
    logic [VW-1:0] r_vel;
    logic          r_valid;
    logic          r_sat;
    logic [CW-1:0] r_pos;
    logic [WCW-1:0] r_win_cnt;

    logic [0:0]     w_state_nxt;
    logic [GW-1:0]  w_timer_nxt;
    logic [CW-1:0]  w_base_nxt;
    logic [VW-1:0]  w_vel_nxt;
    logic           w_valid_nxt;
    logic           w_sat_nxt;
    logic [CW-1:0]  w_pos_nxt;
    logic [WCW-1:0] w_win_cnt_nxt;

    logic           w_gate_ok;
    logic [CW-1:0]  w_delta;
    logic           w_delta_sat;
    logic [VW-1:0]  w_delta_ext;

    assign w_gate_ok   = (gate_len_i >= GW'(2));
    assign w_delta     = count_i - r_base;
    // Outside [-2^(CW-2), 2^(CW-2)) exactly when the two top bits of the delta differ.
    assign w_delta_sat = w_delta[CW-1] ^ w_delta[CW-2];
    assign w_delta_ext = VW'($signed(w_delta));

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_base    <= '0;
            r_vel     <= '0;
            r_valid   <= 1'b0;
            r_sat     <= 1'b0;
            r_pos     <= '0;
            r_win_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_base    <= w_base_nxt;
            r_vel     <= w_vel_nxt;
            r_valid   <= w_valid_nxt;
            r_sat     <= w_sat_nxt;
            r_pos     <= w_pos_nxt;
            r_win_cnt <= w_win_cnt_nxt;
        end
    end

    // Next-state and window-end datapath; a window end re-arms immediately from gate_len_i.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_base_nxt    = r_base;
        w_vel_nxt     = r_vel;
        w_valid_nxt   = 1'b0;
        w_sat_nxt     = r_sat;
        w_pos_nxt     = r_pos;
        w_win_cnt_nxt = r_win_cnt;

        case (r_state)
            S_IDLE: begin
                if (enable_i && w_gate_ok) begin
                    w_state_nxt = S_RUN;
                    w_base_nxt  = count_i;
                    w_timer_nxt = gate_len_i - GW'(1);
                end
            end
            S_RUN: begin
                if (!enable_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_timer != '0) begin
                    w_timer_nxt = r_timer - GW'(1);
                end else begin
                    w_vel_nxt     = w_delta_ext;
                    w_sat_nxt     = w_delta_sat;
                    w_pos_nxt     = count_i;
                    w_win_cnt_nxt = r_win_cnt + WCW'(1);
                    w_valid_nxt   = 1'b1;
                    w_base_nxt    = count_i;
                    if (w_gate_ok) begin
                        w_timer_nxt = gate_len_i - GW'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign vel_o       = r_vel;
    assign vel_valid_o = r_valid;
    assign vel_sat_o   = r_sat;
    assign pos_o       = r_pos;
    assign win_cnt_o   = r_win_cnt;
    assign busy_o      = (r_state == S_RUN);

endmodule

// File: tb/tb_quad_velocity_meter.sv
// Scoreboard bench for quad_velocity_meter: stimulus queues expected window results with their
// strobe cycle, a negedge monitor pops and compares whenever vel_valid_o is seen.
module tb_quad_velocity_meter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [13:0] count_i = '0;
    logic        enable_i = 1'b0;
    logic [23:0] gate_len_i = '0;
    logic [15:0] vel_o;
    logic        vel_valid_o;
    logic        vel_sat_o;
    logic [13:0] pos_o;
    logic [15:0] win_cnt_o;
    logic        busy_o;

    quad_velocity_meter #(.CW(14), .GW(24), .VW(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .count_i     (count_i),
        .enable_i    (enable_i),
        .gate_len_i  (gate_len_i),
        .vel_o       (vel_o),
        .vel_valid_o (vel_valid_o),
        .vel_sat_o   (vel_sat_o),
        .pos_o       (pos_o),
        .win_cnt_o   (win_cnt_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] vel;
        logic        sat;
        logic [13:0] pos;
        logic [15:0] win;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   e0      = 0;
    int   cur     = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Count pattern per test, indexed by edges after the window start edge.
    function automatic logic [13:0] pat(input int t, input int i);
        case (t)
            1: return 14'(100);
            2: return 14'(1000 + i / 4);
            3: return 14'(16380 + i);
            4: return 14'(0 - i);
            5: begin
                if (i < 50)        return 14'(200);
                else if (i <= 100) return 14'(5200);
                else if (i <= 200) return 14'(5200 + (i - 100));
                else if (i <= 300) return 14'(9395);
                else if (i <= 400) return 14'(5298);
                else if (i <= 500) return 14'(1202);
                else               return 14'(5298);
            end
            6: return 14'(2 * i);
            7: return 14'(3 * i + 7);
            default: return 14'(i);
        endcase
    endfunction

    task automatic start(input int t, input int len);
        gate_len_i = 24'(len);
        enable_i   = 1'b1;
        cur        = 0;
        count_i    = pat(t, 0);
        e0         = cyc + 1;
        @(posedge clk_i); #1;
    endtask

    task automatic step_to(input int t, input int upto);
        for (int i = cur + 1; i <= upto; i++) begin
            count_i = pat(t, i);
            @(posedge clk_i); #1;
        end
        cur = upto;
    endtask

    task automatic exp_win(input int idx, input logic [15:0] v, input logic s,
                           input logic [13:0] p, input logic [15:0] w);
        exp_t e;
        e.vel = v; e.sat = s; e.pos = p; e.win = w; e.cyc = e0 + idx;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        enable_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vel"},   32'(vel_o), 32'd0);
        chk({tag, "_sat"},   32'(vel_sat_o), 32'd0);
        chk({tag, "_pos"},   32'(pos_o), 32'd0);
        chk({tag, "_win"},   32'(win_cnt_o), 32'd0);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_valid"}, 32'(vel_valid_o), 32'd0);
    endtask

    // Monitor: every strobe must match the oldest expectation, including its cycle.
    always @(negedge clk_i) begin
        if (!rst_i && vel_valid_o) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                chk("vel",     32'(vel_o), 32'(e.vel));
                chk("sat",     32'(vel_sat_o), 32'(e.sat));
                chk("pos",     32'(pos_o), 32'(e.pos));
                chk("win_cnt", 32'(win_cnt_o), 32'(e.win));
            end
        end else if (q.size() != 0 && cyc > q[0].cyc) begin
            chk("missed_strobe", 32'(cyc), 32'(q[0].cyc));
            void'(q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk_i); #1;
        do_reset();
        chk_zero("reset");

        // Constant count, long window.
        start(1, 1000);
        chk("t1_busy", 32'(busy_o), 32'd1);
        exp_win(1000, 16'd0, 1'b0, 14'd100, 16'd1);
        step_to(1, 1000);
        enable_i = 1'b0;
        step_to(1, 1001);
        chk("t1_idle", 32'(busy_o), 32'd0);
        chk("t1_hold_pos", 32'(pos_o), 32'd100);
        chk("t1_hold_win", 32'(win_cnt_o), 32'd1);

        // Slow ramp, three back-to-back windows.
        do_reset();
        start(2, 400);
        for (int k = 1; k <= 3; k++) exp_win(400 * k, 16'd100, 1'b0, 14'(1000 + 100 * k), 16'(k));
        step_to(2, 1200);
        enable_i = 1'b0;
        step_to(2, 1201);
        chk("t2_idle", 32'(busy_o), 32'd0);

        // Wrap-around, both directions.
        do_reset();
        start(3, 10);
        exp_win(10, 16'd10, 1'b0, 14'd6, 16'd1);
        step_to(3, 10);
        enable_i = 1'b0;
        step_to(3, 11);
        do_reset();
        start(4, 10);
        exp_win(10, 16'hFFF6, 1'b0, 14'd16374, 16'd1);
        step_to(4, 10);
        enable_i = 1'b0;
        step_to(4, 11);

        // Saturation flag and its thresholds.
        do_reset();
        start(5, 100);
        exp_win(100, 16'd5000, 1'b1, 14'd5200, 16'd1);
        exp_win(200, 16'd100,  1'b0, 14'd5300, 16'd2);
        exp_win(300, 16'd4095, 1'b0, 14'd9395, 16'd3);
        exp_win(400, 16'hEFFF, 1'b1, 14'd5298, 16'd4);
        exp_win(500, 16'hF000, 1'b0, 14'd1202, 16'd5);
        exp_win(600, 16'h1000, 1'b1, 14'd5298, 16'd6);
        step_to(5, 600);
        enable_i = 1'b0;
        step_to(5, 601);

        // Gate change mid-window applies next window; abort mid-window; fresh restart.
        do_reset();
        start(6, 20);
        exp_win(20, 16'd40, 1'b0, 14'd40, 16'd1);
        step_to(6, 10);
        gate_len_i = 24'd1000;
        step_to(6, 519);
        chk("t5_busy_before_abort", 32'(busy_o), 32'd1);
        enable_i = 1'b0;
        step_to(6, 520);
        chk("t5_busy_after_abort", 32'(busy_o), 32'd0);
        chk("t5_hold_vel", 32'(vel_o), 32'd40);
        chk("t5_hold_pos", 32'(pos_o), 32'd40);
        chk("t5_hold_win", 32'(win_cnt_o), 32'd1);
        step_to(6, 540);
        start(7, 30);
        exp_win(30, 16'd90, 1'b0, 14'd97, 16'd2);
        step_to(7, 30);
        enable_i = 1'b0;
        step_to(7, 31);

        // Reset mid-window, then invalid gate lengths never start a window.
        do_reset();
        start(8, 20);
        exp_win(20, 16'd20, 1'b0, 14'd20, 16'd1);
        exp_win(40, 16'd20, 1'b0, 14'd40, 16'd2);
        step_to(8, 50);
        do_reset();
        chk_zero("midreset");
        gate_len_i = 24'd1;
        enable_i   = 1'b1;
        repeat (20) begin
            count_i = count_i + 14'd3;
            @(posedge clk_i); #1;
        end
        chk("len1_busy", 32'(busy_o), 32'd0);
        gate_len_i = 24'd0;
        repeat (20) begin
            count_i = count_i + 14'd3;
            @(posedge clk_i); #1;
        end
        chk("len0_busy", 32'(busy_o), 32'd0);
        chk("len0_win", 32'(win_cnt_o), 32'd0);
        enable_i = 1'b0;

        repeat (5) @(posedge clk_i);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
